// File: rtl/snake_body_reader.sv
// Snapshot-and-stream reader for the packed snake-body coordinate registers.
// Streams segments head first over a valid/ready handshake and flags a query-point hit.
module snake_body_reader #(
   parameter int SEG_W     = 4,
   parameter int MAX_SEG   = 4,
   parameter int SKIP_HEAD = 1,
   localparam int IDX_W    = (MAX_SEG > 1) ? $clog2(MAX_SEG) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [3:0]               len,
   input  logic [SEG_W*MAX_SEG-1:0] body_x,
   input  logic [SEG_W*MAX_SEG-1:0] body_y,
   input  logic [SEG_W-1:0]         qx,
   input  logic [SEG_W-1:0]         qy,
   output logic                     seg_valid,
   input  logic                     seg_ready,
   output logic [SEG_W-1:0]         seg_x,
   output logic [SEG_W-1:0]         seg_y,
   output logic [IDX_W-1:0]         seg_idx,
   output logic                     seg_last,
   output logic                     busy,
   output logic                     done,
   output logic                     hit
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t                     state, state_nxt;
   logic [SEG_W*MAX_SEG-1:0]   x_p0, y_p0;
   logic [SEG_W-1:0]           qx_p0, qy_p0;
   logic [IDX_W-1:0]           last_p0;
   logic [IDX_W-1:0]           idx;
   logic [SEG_W-1:0]           cur_x, cur_y;
   logic                       cur_last;
   logic                       accept, xfer;

   // Index of the final segment: len+1 segments, clamped to what the registers hold.
   function automatic logic [IDX_W-1:0] sat_last(input logic [3:0] l);
      if (int'(l) >= MAX_SEG - 1)
         return IDX_W'(MAX_SEG - 1);
      return IDX_W'(l);
   endfunction

   assign accept   = (state == S_IDLE) && start;
   assign xfer     = (state == S_SCAN) && seg_ready;
   assign cur_x    = x_p0[SEG_W*idx +: SEG_W];
   assign cur_y    = y_p0[SEG_W*idx +: SEG_W];
   assign cur_last = (idx == last_p0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_SCAN;
         S_SCAN:  if (seg_ready && cur_last) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Snapshot stage: body, query and length are frozen at the accepted start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_p0    <= '0;
         y_p0    <= '0;
         qx_p0   <= '0;
         qy_p0   <= '0;
         last_p0 <= '0;
         idx     <= '0;
         hit     <= 1'b0;
      end else if (accept) begin
         x_p0    <= body_x;
         y_p0    <= body_y;
         qx_p0   <= qx;
         qy_p0   <= qy;
         last_p0 <= sat_last(len);
         idx     <= '0;
         hit     <= 1'b0;
      end else if (xfer) begin
         if (int'(idx) >= SKIP_HEAD && cur_x == qx_p0 && cur_y == qy_p0)
            hit <= 1'b1;
         if (!cur_last)
            idx <= idx + 1'b1;
      end
   end

   // Stream stage: segment fields are forced to zero whenever no segment is offered.
   always_comb begin
      seg_valid = (state == S_SCAN);
      seg_x     = '0;
      seg_y     = '0;
      seg_idx   = '0;
      seg_last  = 1'b0;
      if (seg_valid) begin
         seg_x    = cur_x;
         seg_y    = cur_y;
         seg_idx  = idx;
         seg_last = cur_last;
      end
      busy = (state != S_IDLE);
      done = (state == S_DONE);
   end

endmodule

// File: tb/tb_snake_body_reader.sv
// Randomized self-checking bench for snake_body_reader against a segment-list model.
module tb_snake_body_reader;

   localparam int SKIP = 1;

   logic        clk = 1'b0;
   logic        rst, start, seg_ready;
   logic [3:0]  len, qx, qy;
   logic [15:0] body_x, body_y;
   logic        seg_valid, seg_last, busy, done, hit;
   logic [3:0]  seg_x, seg_y;
   logic [1:0]  seg_idx;

   int nchecks = 0;
   int nerrors = 0;

   snake_body_reader #(.SEG_W(4), .MAX_SEG(4), .SKIP_HEAD(SKIP)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .body_x(body_x), .body_y(body_y), .qx(qx), .qy(qy),
      .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_x(seg_x), .seg_y(seg_y),
      .seg_idx(seg_idx), .seg_last(seg_last), .busy(busy), .done(done), .hit(hit)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // rmode: 0 always ready, 1 ready pattern 1,0,0 repeating, 2 random ready.
   // sbusy: keep start asserted through SCAN and DONE.
   task automatic do_scan(input logic [15:0] bx, input logic [15:0] by, input logic [3:0] l,
                          input logic [3:0] x, input logic [3:0] y, input int rmode,
                          input bit sbusy);
      logic [3:0] ex[4];
      logic [3:0] ey[4];
      int  n, k, cyc;
      bit  eh, rdy;
      n = (l >= 4'd3) ? 4 : int'(l) + 1;
      for (int i = 0; i < 4; i++) begin
         ex[i] = bx[4*i +: 4];
         ey[i] = by[4*i +: 4];
      end
      eh = 1'b0;
      for (int i = SKIP; i < n; i++)
         if (ex[i] == x && ey[i] == y) eh = 1'b1;

      body_x = bx; body_y = by; len = l; qx = x; qy = y;
      start = 1'b1;
      step();
      start = sbusy;
      body_x = 16'($urandom); body_y = 16'($urandom);
      len = 4'($urandom); qx = 4'($urandom); qy = 4'($urandom);

      k = 0;
      cyc = 0;
      while (k < n && cyc < 40) begin
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         seg_ready = rdy;
         nchecks++;
         if ({seg_valid, busy, done} !== 3'b110) begin
            nerrors++;
            $display("FAIL scan_ctl k=%0d: valid/busy/done=%b required 110", k, {seg_valid, busy, done});
         end
         nchecks++;
         if ({seg_x, seg_y, seg_idx, seg_last} !== {ex[k], ey[k], 2'(k), 1'(k == n - 1)}) begin
            nerrors++;
            $display("FAIL segment k=%0d: got x=%0h y=%0h idx=%0d last=%b required x=%0h y=%0h idx=%0d last=%b",
                     k, seg_x, seg_y, seg_idx, seg_last, ex[k], ey[k], k, (k == n - 1));
         end
         step();
         body_x = 16'($urandom);
         body_y = 16'($urandom);
         if (rdy) k++;
         cyc++;
      end
      if (k < n) begin
         nerrors++;
         $display("FAIL scan_timeout: transfers=%0d required %0d", k, n);
      end
      if (rmode == 0) begin
         nchecks++;
         if (cyc !== n) begin
            nerrors++;
            $display("FAIL latency: cycles=%0d required %0d", cyc, n);
         end
      end
      seg_ready = 1'($urandom);
      nchecks++;
      if ({done, seg_valid, busy, hit} !== {3'b101, eh}) begin
         nerrors++;
         $display("FAIL done_cycle: done/valid/busy/hit=%b required %b", {done, seg_valid, busy, hit}, {3'b101, eh});
      end
      step();
      start = 1'b0;
      nchecks++;
      if ({done, seg_valid, busy, hit} !== {3'b000, eh}) begin
         nerrors++;
         $display("FAIL after_done: done/valid/busy/hit=%b required %b", {done, seg_valid, busy, hit}, {3'b000, eh});
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         start = 1'b1; seg_ready = 1'b1;
         body_x = 16'($urandom); body_y = 16'($urandom);
         len = 4'($urandom); qx = 4'($urandom); qy = 4'($urandom);
         step();
         nchecks++;
         if ({seg_valid, seg_x, seg_y, seg_idx, seg_last, busy, done, hit} !== 15'h0) begin
            nerrors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {seg_valid, seg_x, seg_y, seg_idx, seg_last, busy, done, hit});
         end
      end
      start = 1'b0;
      rst = 1'b1;
      step();
   endtask

   task automatic test_stream();
      do_scan(16'h4321, 16'h8765, 4'd3, 4'd0, 4'd0, 0, 1'b0);
   endtask

   task automatic test_hit();
      do_scan(16'h4321, 16'h8765, 4'd3, 4'd3, 4'd7, 0, 1'b0);
      nchecks++;
      if (hit !== 1'b1) begin
         nerrors++;
         $display("FAIL hit_body: hit=%b required 1", hit);
      end
      do_scan(16'h4321, 16'h8765, 4'd3, 4'd1, 4'd5, 0, 1'b0);
      nchecks++;
      if (hit !== 1'b0) begin
         nerrors++;
         $display("FAIL hit_head_skipped: hit=%b required 0", hit);
      end
   endtask

   task automatic test_backpressure();
      do_scan(16'h4321, 16'h8765, 4'd3, 4'd4, 4'd8, 1, 1'b0);
      do_scan(16'($urandom), 16'($urandom), 4'd3, 4'($urandom), 4'($urandom), 2, 1'b0);
   endtask

   task automatic test_len();
      logic [15:0] bx, by;
      bx = 16'($urandom);
      by = 16'($urandom);
      do_scan(bx, by, 4'd0, bx[3:0], by[3:0], 2, 1'b0);
      nchecks++;
      if (hit !== 1'b0) begin
         nerrors++;
         $display("FAIL single_seg_hit: hit=%b required 0", hit);
      end
      do_scan(16'h4321, 16'h8765, 4'd9, 4'd4, 4'd8, 0, 1'b0);
      do_scan(16'h4321, 16'h8765, 4'd1, 4'd3, 4'd7, 0, 1'b0);
   endtask

   task automatic test_start_busy();
      do_scan(16'h4321, 16'h8765, 4'd3, 4'd2, 4'd6, 2, 1'b1);
   endtask

   task automatic test_reset_mid();
      body_x = 16'h4321; body_y = 16'h8765; len = 4'd3; qx = 4'd2; qy = 4'd6;
      seg_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      nchecks++;
      if ({seg_idx, seg_valid, hit} !== 4'b1011) begin
         nerrors++;
         $display("FAIL pre_abort: idx/valid/hit=%b required 1011", {seg_idx, seg_valid, hit});
      end
      #2;
      rst = 1'b0;
      #1;
      nchecks++;
      if ({seg_valid, seg_x, seg_y, seg_idx, seg_last, busy, done, hit} !== 15'h0) begin
         nerrors++;
         $display("FAIL abort_outputs: got %h required 0",
                  {seg_valid, seg_x, seg_y, seg_idx, seg_last, busy, done, hit});
      end
      step();
      nchecks++;
      if ({done, busy} !== 2'b00) begin
         nerrors++;
         $display("FAIL abort_no_done: done/busy=%b required 00", {done, busy});
      end
      rst = 1'b1;
      step();
      do_scan(16'h4321, 16'h8765, 4'd3, 4'd4, 4'd8, 0, 1'b0);
   endtask

   task automatic test_random();
      logic [15:0] bx, by;
      logic [3:0]  x, y;
      int          p;
      for (int it = 0; it < 20; it++) begin
         bx = 16'($urandom);
         by = 16'($urandom);
         p  = $urandom_range(0, 4);
         if (p < 4) begin
            x = bx[4*p +: 4];
            y = by[4*p +: 4];
         end else begin
            x = 4'($urandom);
            y = 4'($urandom);
         end
         do_scan(bx, by, 4'($urandom), x, y, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; seg_ready = 1'b0;
      len = '0; qx = '0; qy = '0; body_x = '0; body_y = '0;
      test_reset();
      test_stream();
      test_hit();
      test_backpressure();
      test_len();
      test_start_busy();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
